fifo_sr_shared: RTL
===================

FIFO_SR_SHARED -- requirements
Module: fifo_sr_shared

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per word.
REQ-002 Parameter DEPTH, default 8, shared data locations; power of two, at least 2.
REQ-003 Parameter FLUX, default 4, number of independent logical queues (fluxes); at least 2.
REQ-004 Parameter RESERVE, default 1, locations guaranteed per flux; FLUX*RESERVE SHALL NOT exceed DEPTH (elaboration error otherwise).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 write  input  1  write request for din this cycle.
REQ-008 din  input  TAG_W+DATA_WIDTH  {tag, payload}; tag in MSBs selects the flux; TAG_W=$clog2(FLUX).
REQ-009 full  output  FLUX  per-flux "write would be refused".
REQ-010 read  input  FLUX  per-flux read request (pop).
REQ-011 empty  output  FLUX  per-flux "no data".
REQ-012 dout  output  TAG_W+DATA_WIDTH  {flux index, head payload} of the serviced flux; first-word fall-through.
REQ-013 occupancy  output  FLUX*($clog2(DEPTH)+1)  per-flux stored-word count, flux 0 in LSBs.

Function
REQ-014 Storage: shared data RAM, next-pointer RAM (linked list per flux), per-flux head/tail/count registers, free-address FIFO of depth DEPTH.
REQ-015 Write accepted when write=1 and full[tag]=0: pop free address A; data RAM[A]<=payload; if count[tag]>0 next[tail[tag]]<=A, else head[tag]<=A; tail[tag]<=A; count[tag]+1.
REQ-016 Write with full[tag]=1: dropped, no state change.
REQ-017 Read service: the lowest set bit of read with empty=0 is serviced; other set bits ignored that cycle; read of an empty flux ignored.
REQ-018 Serviced read of flux f: push head[f] onto free FIFO; head[f]<=next[head[f]]; count[f]-1.
REQ-019 dout combinationally equals {f, RAM[head[f]]} for the lowest-index set read bit; with no read bit set dout = {0, RAM[head[0]]}; value undefined for an empty flux.
REQ-020 Reservation: deficit(g)=max(0, RESERVE-count[g]); full[f]=1 when free_count <= sum of deficit(g) over g!=f, or free_count=0.
REQ-021 full, empty and occupancy derive from registered state only; a same-cycle read does not clear full.
REQ-022 Simultaneous write and read, same flux, count=1: new address becomes head and tail; count stays 1.
REQ-023 Simultaneous free-FIFO push and pop: free_count unchanged; the popped address is never the one being pushed.
REQ-024 Write latency: data readable at dout on the cycle after acceptance; empty deasserts on that same cycle.

Reset
REQ-025 While rst=0: free FIFO holds addresses 0..DEPTH-1 in order, free_count=DEPTH, all counts 0, empty all 1, full all 0, occupancy all 0; data and next RAMs not reset.
REQ-026 rst asserted mid-operation discards all queued data immediately, with no clock edge required.

Configuration
REQ-027 Macro FIFO_SR_ERR_EN defined: adds output err (2 bits); err[0] sticky on a write dropped while full, err[1] sticky on a read request to an empty flux; cleared only by reset.
REQ-028 Macro FIFO_SR_ERR_EN undefined: no err port and no associated logic.

Structure
REQ-029 Package fifo_sr_pkg holds the TAG_W and address-width localparam functions, the flux-index typedef and the occupancy-width helper.
REQ-030 Sub-module fifo_free_list: address FIFO with push/pop/count and reset initialisation to 0..DEPTH-1.

Verification
REQ-031 After reset, write {2'd2,8'hA5} -> next cycle empty[2]=0 and occupancy[2]=1; with read=4'b0100, dout={2'd2,8'hA5}, then empty[2]=1.
REQ-032 Interleave flux0 writes 01,02,03 with flux1 writes 11,12 -> reads of flux0 return 01,02,03 in order and flux1 returns 11,12.
REQ-033 Defaults: 5 writes to flux0 -> full[0]=1 and full[1..3]=0; a 6th flux0 write is dropped; 3 further writes, one each to fluxes 1..3, are all accepted.
REQ-034 Flux3 holds 1 word; same-cycle write 8'h77 and read[3] -> old word on dout; next cycle occupancy[3]=1 and dout={2'd3,8'h77}.
REQ-035 Three fluxes non-empty, rst pulsed low between edges -> empty=4'b1111 immediately; a subsequent 8 writes spread over the fluxes within their limits are all accepted.
REQ-036 With FIFO_SR_ERR_EN, read[1]=1 on empty flux1 -> err[1]=1 and it stays set until reset; err[0]=0.

Source files
------------

// File: rtl/fifo_sr_pkg.sv
// Shared helpers for the shared-storage multi-flux FIFO: width functions and the flux index type.
package fifo_sr_pkg;

  localparam int unsigned FLUX_IDX_W = 8;

  typedef logic [FLUX_IDX_W-1:0] flux_idx_t;

  function automatic int unsigned tag_w(input int unsigned flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned occ_w(input int unsigned depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_free_list.sv
// Free-address FIFO; resets to hold every data location 0..DEPTH-1 in ascending order.
module fifo_free_list
  import fifo_sr_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [addr_w(DEPTH)-1:0]    push_addr,
  input  logic                        pop,
  output logic [addr_w(DEPTH)-1:0]    pop_addr_c,
  output logic [occ_w(DEPTH)-1:0]     count
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned CW = occ_w(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign pop_addr_c = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= AW'(i);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= CW'(DEPTH);
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_addr;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fifo_sr_shared.sv
// Multi-flux FIFO over one shared data RAM with linked-list queues and per-flux reservations.
// Optional macro FIFO_SR_ERR_EN adds a 2-bit sticky err output (write-while-full, read-of-empty).
module fifo_sr_shared
  import fifo_sr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FLUX       = 4,
  parameter int unsigned RESERVE    = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 write,
  input  logic [tag_w(FLUX)+DATA_WIDTH-1:0]    din,
  output logic [FLUX-1:0]                      full,
  input  logic [FLUX-1:0]                      read,
  output logic [FLUX-1:0]                      empty,
  output logic [tag_w(FLUX)+DATA_WIDTH-1:0]    dout,
  output logic [FLUX*occ_w(DEPTH)-1:0]         occupancy
`ifdef FIFO_SR_ERR_EN
  ,
  output logic [1:0]                           err
`endif
);

  localparam int unsigned TW = tag_w(FLUX);
  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned OW = occ_w(DEPTH);

  if (FLUX * RESERVE > DEPTH) begin : g_bad_reserve
    $error("fifo_sr_shared: FLUX*RESERVE exceeds DEPTH");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sr_shared: DEPTH must be a power of two, at least 2");
  end
  if (FLUX < 2) begin : g_bad_flux
    $error("fifo_sr_shared: FLUX must be at least 2");
  end

  logic [DATA_WIDTH-1:0] data_ram [DEPTH];
  logic [AW-1:0]         next_ram [DEPTH];
  logic [AW-1:0]         head     [FLUX];
  logic [AW-1:0]         tail     [FLUX];
  logic [OW-1:0]         cnt      [FLUX];
  logic [OW-1:0]         defic    [FLUX];

  logic [TW-1:0]         tag;
  logic [DATA_WIDTH-1:0] payload;
  logic                  wr_acc;
  logic                  svc_vld;
  logic [TW-1:0]         svc_idx;
  logic [TW-1:0]         dsel;
  logic [FLUX-1:0]       wr_hit;
  logic [FLUX-1:0]       rd_hit;
  logic [OW-1:0]         others;
  logic [AW-1:0]         free_addr;
  logic [OW-1:0]         free_cnt;

  assign tag     = din[TW+DATA_WIDTH-1:DATA_WIDTH];
  assign payload = din[DATA_WIDTH-1:0];
  assign wr_acc  = write && !full[tag];
  assign dout    = {dsel, data_ram[head[dsel]]};

  fifo_free_list #(.DEPTH(DEPTH)) u_free (
    .clk        (clk),
    .rst        (rst),
    .push       (svc_vld),
    .push_addr  (head[svc_idx]),
    .pop        (wr_acc),
    .pop_addr_c (free_addr),
    .count      (free_cnt)
  );

  // Status flags come only from registered counts, never from same-cycle requests.
  always_comb begin
    others = '0;
    for (int g = 0; g < FLUX; g++) begin
      defic[g] = (cnt[g] < OW'(RESERVE)) ? (OW'(RESERVE) - cnt[g]) : '0;
      empty[g] = (cnt[g] == '0);
      occupancy[g*OW +: OW] = cnt[g];
    end
    for (int f = 0; f < FLUX; f++) begin
      others = '0;
      for (int g = 0; g < FLUX; g++) begin
        if (g != f) others = others + defic[g];
      end
      full[f] = (free_cnt == '0) || (free_cnt <= others);
    end
  end

  // Lowest set read bit drives dout; lowest set non-empty read bit is serviced.
  always_comb begin
    svc_vld = 1'b0;
    svc_idx = '0;
    dsel    = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (read[i] && !empty[i]) begin
        svc_vld = 1'b1;
        svc_idx = TW'(i);
      end
      if (read[i]) dsel = TW'(i);
    end
    wr_hit = wr_acc  ? (FLUX'(1) << tag)     : '0;
    rd_hit = svc_vld ? (FLUX'(1) << svc_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      data_ram[free_addr] <= payload;
      if (cnt[tag] != '0) next_ram[tail[tag]] <= free_addr;
    end
  end

  // A write racing the pop of a single-word flux makes the new word both head and tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < FLUX; f++) begin
        head[f] <= '0;
        tail[f] <= '0;
        cnt[f]  <= '0;
      end
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (wr_hit[f]) tail[f] <= free_addr;
        if (wr_hit[f] && ((cnt[f] == '0) || (rd_hit[f] && (cnt[f] == OW'(1)))))
          head[f] <= free_addr;
        else if (rd_hit[f])
          head[f] <= next_ram[head[f]];
        if (wr_hit[f] && !rd_hit[f])      cnt[f] <= cnt[f] + OW'(1);
        else if (rd_hit[f] && !wr_hit[f]) cnt[f] <= cnt[f] - OW'(1);
      end
    end
  end

`ifdef FIFO_SR_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= '0;
    end else begin
      if (write && full[tag])  err[0] <= 1'b1;
      if (|(read & empty))     err[1] <= 1'b1;
    end
  end
`endif

endmodule
